// File: rtl/instruction_decode_pkg.sv
// instruction_decode_pkg: shared widths, alu_op bit indices, bypass bus layouts and decode helpers
// Optional feature macro FORWARD_EN selects operand bypassing in fwd_src().
package instruction_decode_pkg;

   localparam int FETCH_TO_DEC_BUS_WD = 64;
   localparam int BR_BUS_WD           = 33;
   localparam int DEC_TO_EXE_BUS_WD   = 148;
   localparam int WB_TO_RF_BUS_WD     = 38;
   localparam int EXE_FWD_BUS_WD      = 40;
   localparam int MEM_FWD_BUS_WD      = 39;
   localparam int ALU_OP_WD           = 12;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   typedef enum logic [4:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR,
      OP_SLLI, OP_SRLI, OP_SRAI, OP_ADDI, OP_LU12I, OP_LD, OP_ST,
      OP_JIRL, OP_B, OP_BL, OP_BEQ, OP_BNE
   } op_e;

   typedef struct packed {
      logic        valid;
      logic        gr_we;
      logic        is_load;
      logic [4:0]  dest;
      logic [31:0] result;
   } exe_fwd_t;

   typedef struct packed {
      logic        valid;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
   } mem_fwd_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_rf_t;

   // Opcode classes live in inst[31:15]; '?' covers immediate/register fields.
   function automatic op_e decode_op(input logic [31:0] inst);
      casez (inst[31:15])
         17'h00020:            return OP_ADD;
         17'h00022:            return OP_SUB;
         17'h00024:            return OP_SLT;
         17'h00025:            return OP_SLTU;
         17'h00028:            return OP_NOR;
         17'h00029:            return OP_AND;
         17'h0002a:            return OP_OR;
         17'h0002b:            return OP_XOR;
         17'h00081:            return OP_SLLI;
         17'h00089:            return OP_SRLI;
         17'h00091:            return OP_SRAI;
         17'b0000001010???????: return OP_ADDI;
         17'b0001010??????????: return OP_LU12I;
         17'b0010100010???????: return OP_LD;
         17'b0010100110???????: return OP_ST;
         17'b010011???????????: return OP_JIRL;
         17'b010100???????????: return OP_B;
         17'b010101???????????: return OP_BL;
         17'b010110???????????: return OP_BEQ;
         17'b010111???????????: return OP_BNE;
         default:              return OP_NOP;
      endcase
   endfunction

   // Returns {stall, value}. The bypassed value is only consumed when there is
   // no stall, so the same priority mux (EXE > MEM > WB > regfile) serves both
   // builds; without bypassing every match stalls and the value equals the regfile.
   function automatic logic [32:0] fwd_src(input logic [4:0] a, input logic used,
                                           input logic [31:0] rf, input exe_fwd_t e,
                                           input mem_fwd_t m, input wb_rf_t w);
      logic he, hm, hw;
      he = used && a != 5'd0 && e.valid && e.gr_we && e.dest == a;
      hm = used && a != 5'd0 && m.valid && m.gr_we && m.dest == a;
      hw = used && a != 5'd0 && w.we && w.waddr == a;
`ifdef FORWARD_EN
      return {he & e.is_load, he ? e.result : hm ? m.result : hw ? w.wdata : rf};
`else
      return {he | hm | hw | (e.is_load & 1'b0), he ? e.result : hm ? m.result : hw ? w.wdata : rf};
`endif
   endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// instruction_decode_regfile: 32x32 register file, two async read ports, one sync write port, r0 reads 0
// Ports: clk; i_raddr1/o_rdata1, i_raddr2/o_rdata2 read ports; i_we/i_waddr/i_wdata write port.
module instruction_decode_regfile (
   input  logic        clk,
   input  logic [4:0]  i_raddr1,
   output logic [31:0] o_rdata1,
   input  logic [4:0]  i_raddr2,
   output logic [31:0] o_rdata2,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata
);
   logic [31:0] r_regs [32];

   always_ff @(posedge clk)
      if (i_we && i_waddr != 5'd0) r_regs[i_waddr] <= i_wdata;

   assign o_rdata1 = i_raddr1 == 5'd0 ? 32'd0 : r_regs[i_raddr1];
   assign o_rdata2 = i_raddr2 == 5'd0 ? 32'd0 : r_regs[i_raddr2];
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: LA32R-subset decode stage with RAW hazard detection and in-decode branch resolution
// Ports: clk, reset (sync, active-high); fetch_to_dec_valid/fetch_to_decode_bus {inst,pc} in,
// dec_allowin out; branch_bus {taken,target} out; exe_allowin in, dec_to_exe_valid/dec_to_exe_bus out;
// exe_fwd_bus, mem_fwd_bus, wb_to_rf_bus in (producer info and regfile write).
// Build option: define FORWARD_EN to bypass EXE/MEM/WB results (stall only on load-use).
module instruction_decode
   import instruction_decode_pkg::*;
(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_to_dec_valid,
   input  logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
   output logic                           dec_allowin,
   output logic [BR_BUS_WD-1:0]           branch_bus,
   input  logic                           exe_allowin,
   output logic                           dec_to_exe_valid,
   output logic [DEC_TO_EXE_BUS_WD-1:0]   dec_to_exe_bus,
   input  logic [EXE_FWD_BUS_WD-1:0]      exe_fwd_bus,
   input  logic [MEM_FWD_BUS_WD-1:0]      mem_fwd_bus,
   input  logic [WB_TO_RF_BUS_WD-1:0]     wb_to_rf_bus
);
   logic                           r_dec_valid;
   logic [FETCH_TO_DEC_BUS_WD-1:0] r_inst_bus;
   logic [31:0]    w_inst, w_pc, w_rf1, w_rf2, w_rj_val, w_r2_val, w_src1, w_src2;
   logic [31:0]    w_offs16, w_offs26, w_br_target;
   logic [4:0]     w_rd, w_rj, w_rk, w_raddr2, w_dest;
   logic [32:0]    w_fwd1, w_fwd2;
   logic [ALU_OP_WD-1:0] w_alu_op;
   logic           w_use_rj, w_use_r2, w_rd_src, w_link, w_imm12, w_shift;
   logic           w_ready_go, w_br_cond, w_br_taken, w_gr_we;
   op_e            w_op;
   exe_fwd_t       w_exe;
   mem_fwd_t       w_mem;
   wb_rf_t         w_wb;

   assign w_exe = exe_fwd_bus;
   assign w_mem = mem_fwd_bus;
   assign w_wb  = wb_to_rf_bus;
   assign w_inst = r_inst_bus[63:32];
   assign w_pc   = r_inst_bus[31:0];
   assign w_rd   = w_inst[4:0];
   assign w_rj   = w_inst[9:5];
   assign w_rk   = w_inst[14:10];
   assign w_op   = decode_op(w_inst);

   assign w_shift  = w_op inside {OP_SLLI, OP_SRLI, OP_SRAI};
   assign w_rd_src = w_op inside {OP_ST, OP_BEQ, OP_BNE};
   assign w_link   = w_op inside {OP_BL, OP_JIRL};
   assign w_imm12  = w_op inside {OP_ADDI, OP_LD, OP_ST};
   assign w_use_rj = !(w_op inside {OP_NOP, OP_LU12I, OP_B, OP_BL});
   assign w_use_r2 = w_rd_src | (w_op inside {OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR});
   assign w_raddr2 = w_rd_src ? w_rd : w_rk;

   instruction_decode_regfile u_regfile (
      .clk      (clk),
      .i_raddr1 (w_rj),
      .o_rdata1 (w_rf1),
      .i_raddr2 (w_raddr2),
      .o_rdata2 (w_rf2),
      .i_we     (w_wb.we),
      .i_waddr  (w_wb.waddr),
      .i_wdata  (w_wb.wdata)
   );

   // Unused source fields are masked here so they can never raise a stall.
   assign w_fwd1     = fwd_src(w_rj, w_use_rj, w_rf1, w_exe, w_mem, w_wb);
   assign w_fwd2     = fwd_src(w_raddr2, w_use_r2, w_rf2, w_exe, w_mem, w_wb);
   assign w_rj_val   = w_fwd1[31:0];
   assign w_r2_val   = w_fwd2[31:0];
   assign w_ready_go = ~(w_fwd1[32] | w_fwd2[32]);

   assign w_offs16    = {{14{w_inst[25]}}, w_inst[25:10], 2'b00};
   assign w_offs26    = {{4{w_inst[9]}}, w_inst[9:0], w_inst[25:10], 2'b00};
   assign w_br_target = w_op == OP_JIRL ? w_rj_val + w_offs16 :
                        w_op inside {OP_B, OP_BL} ? w_pc + w_offs26 : w_pc + w_offs16;
   assign w_br_cond   = (w_op inside {OP_B, OP_BL, OP_JIRL}) |
                        (w_op == OP_BEQ && w_rj_val == w_r2_val) |
                        (w_op == OP_BNE && w_rj_val != w_r2_val);
   // Reset gating keeps a stalled branch from redirecting fetch in the reset cycle.
   assign w_br_taken  = r_dec_valid & w_ready_go & w_br_cond & ~reset;
   assign branch_bus  = w_br_taken ? {1'b1, w_br_target} : '0;

   always_comb begin
      w_alu_op           = '0;
      w_alu_op[ALU_ADD]  = w_op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_JIRL, OP_BL};
      w_alu_op[ALU_SUB]  = w_op == OP_SUB;
      w_alu_op[ALU_SLT]  = w_op == OP_SLT;
      w_alu_op[ALU_SLTU] = w_op == OP_SLTU;
      w_alu_op[ALU_AND]  = w_op == OP_AND;
      w_alu_op[ALU_NOR]  = w_op == OP_NOR;
      w_alu_op[ALU_OR]   = w_op == OP_OR;
      w_alu_op[ALU_XOR]  = w_op == OP_XOR;
      w_alu_op[ALU_SLL]  = w_op == OP_SLLI;
      w_alu_op[ALU_SRL]  = w_op == OP_SRLI;
      w_alu_op[ALU_SRA]  = w_op == OP_SRAI;
      w_alu_op[ALU_LUI]  = w_op == OP_LU12I;
   end

   assign w_src1  = w_link ? w_pc : w_rj_val;
   assign w_src2  = w_imm12 ? {{20{w_inst[21]}}, w_inst[21:10]} :
                    w_shift ? {27'd0, w_rk} :
                    w_op == OP_LU12I ? {w_inst[24:5], 12'd0} :
                    w_link ? 32'd4 : w_r2_val;
   assign w_dest  = w_op == OP_BL ? 5'd1 : w_rd;
   assign w_gr_we = !(w_op inside {OP_NOP, OP_ST, OP_B, OP_BEQ, OP_BNE}) && w_dest != 5'd0;

   assign dec_allowin      = ~r_dec_valid | (w_ready_go & exe_allowin);
   assign dec_to_exe_valid = r_dec_valid & w_ready_go & ~reset;
   assign dec_to_exe_bus   = {w_alu_op, w_op == OP_LD, w_op == OP_ST, w_gr_we, w_dest,
                              w_src1, w_src2, w_r2_val, w_pc};

   // A taken branch squashes the wrong-path instruction accepted in the same cycle.
   always_ff @(posedge clk)
      if (reset) begin
         r_dec_valid <= 1'b0;
         r_inst_bus  <= '0;
      end else begin
         if (dec_allowin) r_dec_valid <= fetch_to_dec_valid & ~w_br_taken;
         if (fetch_to_dec_valid & dec_allowin) r_inst_bus <= fetch_to_decode_bus;
      end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: scoreboard bench for instruction_decode (directed vectors, expected bus queue)
module tb_instruction_decode;
`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic         clk, reset, fetch_to_dec_valid, exe_allowin, dec_allowin, dec_to_exe_valid;
   logic [63:0]  fetch_to_decode_bus;
   logic [32:0]  branch_bus;
   logic [147:0] dec_to_exe_bus;
   logic [39:0]  exe_fwd_bus;
   logic [38:0]  mem_fwd_bus;
   logic [37:0]  wb_to_rf_bus;
   logic [147:0] q[$];
   logic [147:0] e_or;
   logic [31:0]  rf_m[32];
   int           n_cmp, n_fail;

   instruction_decode dut (
      .clk                 (clk),
      .reset               (reset),
      .fetch_to_dec_valid  (fetch_to_dec_valid),
      .fetch_to_decode_bus (fetch_to_decode_bus),
      .dec_allowin         (dec_allowin),
      .branch_bus          (branch_bus),
      .exe_allowin         (exe_allowin),
      .dec_to_exe_valid    (dec_to_exe_valid),
      .dec_to_exe_bus      (dec_to_exe_bus),
      .exe_fwd_bus         (exe_fwd_bus),
      .mem_fwd_bus         (mem_fwd_bus),
      .wb_to_rf_bus        (wb_to_rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [147:0] pk(input logic [11:0] alu, input logic ld, input logic st,
                                       input logic we, input logic [4:0] d, input logic [31:0] s1,
                                       input logic [31:0] s2, input logic [31:0] rkd, input logic [31:0] pc);
      return {alu, ld, st, we, d, s1, s2, rkd, pc};
   endfunction

   task automatic check(input string nm, input logic [147:0] act, input logic [147:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted decode output must match the oldest expectation.
   always @(negedge clk)
      if (dec_to_exe_valid && exe_allowin) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got bus %h, required no issue", dec_to_exe_bus);
         end else begin
            logic [147:0] exp;
            exp = q.pop_front();
            if (dec_to_exe_bus !== exp) begin
               n_fail++;
               $display("FAIL issue_bus: got %h, required %h", dec_to_exe_bus, exp);
            end
         end
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; returns just after the posedge that accepted the instruction.
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      int n;
      logic a;
      n = 0;
      fetch_to_dec_valid  = 1'b1;
      fetch_to_decode_bus = {inst, pc};
      do begin
         @(negedge clk);
         a = dec_allowin;
         @(posedge clk);
         n++;
      end while (!a && n < 50);
      #1;
      fetch_to_dec_valid = 1'b0;
      if (!a) begin
         n_cmp++;
         n_fail++;
         $display("FAIL issue_timeout: got dec_allowin 0 for %0d cycles, required 1", n);
      end
   endtask

   task automatic branch_case(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [32:0] exp_br);
      issue(inst, pc);
      fetch_to_dec_valid  = 1'b1;
      fetch_to_decode_bus = {32'h02801c02, pc + 32'd4};
      @(negedge clk);
      check({nm, "_branch_bus"}, 148'(branch_bus), 148'(exp_br));
      step();
      fetch_to_dec_valid = 1'b0;
      @(negedge clk);
      check({nm, "_squash"}, 148'(dec_to_exe_valid), 148'(0));
      check({nm, "_bus_clear"}, 148'(branch_bus), 148'(0));
      step();
   endtask

   // Producer of register pd walks EXE -> MEM -> WB while the consumer waits in decode.
   task automatic hazard_case(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                              input logic [4:0] pd, input logic ld, input logic [31:0] exe_res,
                              input logic [31:0] res, input int exp_stall);
      int stall;
      logic ok;
      stall = 0;
      issue(inst, pc);
      for (int c = 0; c < 6; c++) begin
         exe_fwd_bus  = c == 0 ? {1'b1, 1'b1, ld, pd, exe_res} : '0;
         mem_fwd_bus  = c == 1 ? {1'b1, 1'b1, pd, res} : '0;
         wb_to_rf_bus = c == 2 ? {1'b1, pd, res} : '0;
         @(negedge clk);
         ok = dec_to_exe_valid;
         if (!ok) stall++;
         @(posedge clk);
         if (c == 2) rf_m[pd] = res;
         #1;
         if (ok) break;
      end
      exe_fwd_bus  = '0;
      mem_fwd_bus  = '0;
      wb_to_rf_bus = '0;
      check({nm, "_stall_cycles"}, 148'(stall), 148'(exp_stall));
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1;
      fetch_to_dec_valid = 1'b0;
      fetch_to_decode_bus = '0;
      exe_allowin = 1'b1;
      exe_fwd_bus = '0;
      mem_fwd_bus = '0;
      wb_to_rf_bus = '0;
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_allowin", 148'(dec_allowin), 148'(1));
      check("rst_valid", 148'(dec_to_exe_valid), 148'(0));
      check("rst_branch_bus", 148'(branch_bus), 148'(0));
      step();
      reset = 1'b0;
      for (int i = 1; i < 32; i++) begin
         wb_to_rf_bus = {1'b1, 5'(i), 32'h100 + 32'(i)};
         @(posedge clk);
         rf_m[i] = 32'h100 + 32'(i);
         #1;
      end
      wb_to_rf_bus = '0;

      // addi.w r1,r0,5
      q.push_back(pk(12'h001, 0, 0, 1, 5'd1, 32'd0, 32'd5, rf_m[5], 32'h1c000000));
      issue(32'h02801401, 32'h1c000000);
      @(negedge clk);
      check("addi_one_cycle", 148'(dec_to_exe_valid), 148'(1));
      step();

      // beq r0,r0,4 ; bl +0x400 ; jirl r13,r9,8 (all taken, wrong path squashed)
      q.push_back(pk(12'h000, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h1c000010));
      branch_case("beq", 32'h58001000, 32'h1c000010, {1'b1, 32'h1c000020});
      q.push_back(pk(12'h001, 0, 0, 1, 5'd1, 32'h1c000100, 32'd4, 32'd0, 32'h1c000100));
      branch_case("bl", 32'h54040000, 32'h1c000100, {1'b1, 32'h1c000500});
      q.push_back(pk(12'h001, 0, 0, 1, 5'd13, 32'h1c000200, 32'd4, rf_m[2], 32'h1c000200));
      branch_case("jirl", 32'h4c00092d, 32'h1c000200, {1'b1, rf_m[9] + 32'd8});

      // bne r1,r1 is not taken
      q.push_back(pk(12'h000, 0, 0, 0, 5'd1, rf_m[1], rf_m[1], rf_m[1], 32'h1c000300));
      issue(32'h5c001021, 32'h1c000300);
      @(negedge clk);
      check("bne_not_taken", 148'(branch_bus), 148'(0));
      step();

      // st.w r12,r13,8 ; slli.w r10,r3,4 ; lu12i.w r11,0x12345
      q.push_back(pk(12'h001, 0, 1, 0, 5'd12, rf_m[13], 32'd8, rf_m[12], 32'h1c000400));
      issue(32'h298021ac, 32'h1c000400);
      q.push_back(pk(12'h100, 0, 0, 1, 5'd10, rf_m[3], 32'd4, rf_m[4], 32'h1c000404));
      issue(32'h0040906a, 32'h1c000404);
      q.push_back(pk(12'h800, 0, 0, 1, 5'd11, rf_m[5], 32'h12345000, rf_m[26], 32'h1c000408));
      issue(32'h142468ab, 32'h1c000408);
      step();

      // add.w r3,r1,r2 behind an ALU producer of r1 (result 7)
      q.push_back(pk(12'h001, 0, 0, 1, 5'd3, 32'h7, rf_m[2], rf_m[2], 32'h1c000500));
      hazard_case("raw_alu", 32'h00100823, 32'h1c000500, 5'd1, 1'b0, 32'h7, 32'h7, FWD ? 0 : 3);

      // add.w r5,r4,r4 behind ld.w r4 (load-use)
      q.push_back(pk(12'h001, 0, 0, 1, 5'd5, 32'h44, 32'h44, 32'h44, 32'h1c000600));
      hazard_case("load_use", 32'h00101085, 32'h1c000600, 5'd4, 1'b1, 32'hdeadbeef, 32'h44, FWD ? 1 : 3);

      // or.w r6,r1,r2 held by exe_allowin=0 for 3 cycles, xor.w r7 waiting behind it
      e_or = pk(12'h040, 0, 0, 1, 5'd6, rf_m[1], rf_m[2], rf_m[2], 32'h1c000700);
      q.push_back(e_or);
      issue(32'h00150826, 32'h1c000700);
      exe_allowin = 1'b0;
      q.push_back(pk(12'h080, 0, 0, 1, 5'd7, rf_m[1], rf_m[2], rf_m[2], 32'h1c000704));
      fetch_to_dec_valid  = 1'b1;
      fetch_to_decode_bus = {32'h00158827, 32'h1c000704};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_allowin", 148'(dec_allowin), 148'(0));
         check("hold_bus_stable", dec_to_exe_bus, e_or);
         step();
      end
      exe_allowin = 1'b1;
      issue(32'h00158827, 32'h1c000704);
      step();

      // illegal word -> NOP, then addi.w r8,r9,-1; an EXE load to r31 matches only unused fields
      exe_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd31, 32'h0};
      q.push_back(pk(12'h000, 0, 0, 0, 5'd31, rf_m[31], rf_m[31], rf_m[31], 32'h1c000800));
      issue(32'hffffffff, 32'h1c000800);
      @(negedge clk);
      check("nop_no_stall", 148'(dec_to_exe_valid), 148'(1));
      step();
      q.push_back(pk(12'h001, 0, 0, 1, 5'd8, rf_m[9], 32'hffffffff, rf_m[31], 32'h1c000804));
      issue(32'h02bffd28, 32'h1c000804);
      @(negedge clk);
      check("unused_rk_no_stall", 148'(dec_to_exe_valid), 148'(1));
      step();
      exe_fwd_bus = '0;

      // beq r1,r1 stalled by a load to r1, reset arrives as the hazard clears
      exe_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd1, 32'h0};
      issue(32'h58001021, 32'h1c000900);
      @(negedge clk);
      check("stall_held", 148'(dec_allowin), 148'(0));
      step();
      reset = 1'b1;
      exe_fwd_bus = '0;
      @(negedge clk);
      check("rst_no_branch", 148'(branch_bus), 148'(0));
      check("rst_no_issue", 148'(dec_to_exe_valid), 148'(0));
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_discard_valid", 148'(dec_to_exe_valid), 148'(0));
      check("rst_discard_allowin", 148'(dec_allowin), 148'(1));
      step();

      begin
         int n;
         n = 0;
         while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("scoreboard_drained", 148'(q.size()), 148'(0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
